// File: rtl/gpio_move_ctl.sv
// Player-2 movement pin conditioner: 2-flop sync, per-line debounce, left/right arbitration.
// Optional GPIO_LAST_WINS_EN: with both lines held, the most recent press owns the output.
module gpio_move_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_left_raw,
  input  logic gpio_right_raw,
  output logic gpio_left,
  output logic gpio_right,
  output logic dir_change
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StNone  = 2'd0;
  localparam logic [1:0] StLeft  = 2'd1;
  localparam logic [1:0] StRight = 2'd2;

  // Bit 0 is the left line, bit 1 the right line.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [1:0]       prev_state_q;
`ifdef GPIO_LAST_WINS_EN
  logic [1:0]       deb_prev_q;
`endif

  assign raw = {gpio_right_raw, gpio_left_raw};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (s2[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (deb_q)
      2'b00:   state_d = StNone;
      2'b01:   state_d = StLeft;
      2'b10:   state_d = StRight;
      default: begin
`ifdef GPIO_LAST_WINS_EN
        // Newcomer takes over; a simultaneous rise goes to the right line.
        if (deb_q[1] && !deb_prev_q[1]) begin
          state_d = StRight;
        end else if (deb_q[0] && !deb_prev_q[0]) begin
          state_d = StLeft;
        end else begin
          state_d = state_q;
        end
`else
        state_d = StNone;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= '0;
      s2           <= '0;
      deb_q        <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      state_q      <= StNone;
      prev_state_q <= StNone;
      dir_change   <= 1'b0;
`ifdef GPIO_LAST_WINS_EN
      deb_prev_q   <= '0;
`endif
    end else begin
      s1           <= raw;
      s2           <= s1;
      deb_q        <= deb_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      state_q      <= state_d;
      prev_state_q <= state_q;
      dir_change   <= (state_q != prev_state_q);
`ifdef GPIO_LAST_WINS_EN
      deb_prev_q   <= deb_q;
`endif
    end
  end

  assign gpio_left  = (state_q == StLeft);
  assign gpio_right = (state_q == StRight);

endmodule

// File: tb/tb_gpio_move_ctl.sv
// Scoreboard bench for gpio_move_ctl with DEBOUNCE_CYCLES=4; expected output changes are queued
// with their cycle numbers and matched by an independent monitor.
module tb_gpio_move_ctl;

  localparam int unsigned Dc = 4;
  // Raw change set after edge c is captured at c+1 and reaches gpio_* at c+1+Dc+2.
  localparam int Lat = Dc + 3;

  typedef struct {
    int   cyc;
    logic l;
    logic r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gpio_left_raw = 1'b1;
  logic gpio_right_raw = 1'b1;
  logic gpio_left;
  logic gpio_right;
  logic dir_change;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   last_wins;
  exp_t q[$];

  gpio_move_ctl #(
    .DEBOUNCE_CYCLES(Dc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_left_raw (gpio_left_raw),
    .gpio_right_raw(gpio_right_raw),
    .gpio_left     (gpio_left),
    .gpio_right    (gpio_right),
    .dir_change    (dir_change)
  );

  always #5 clk = ~clk;

  // Monitor: every output change must match the head of the queue; dir_change follows a change.
  logic [1:0] prev_pair = 2'b00;
  logic [1:0] pair;
  logic       chg_prev = 1'b0;
  logic       exp_dir;
  logic       rst_edge;
  exp_t       e;
  always begin
    @(posedge clk);
    cyc++;
    rst_edge = rst;
    #1;
    if (mon_en) begin
      pair    = {gpio_left, gpio_right};
      exp_dir = rst_edge ? 1'b0 : chg_prev;
      checks++;
      if (dir_change !== exp_dir) begin
        failures++;
        $display("FAIL dir_change cyc=%0d got=%b expected=%b", cyc, dir_change, exp_dir);
      end
      checks++;
      if (pair === 2'b11) begin
        failures++;
        $display("FAIL exclusive cyc=%0d got={l,r}=%b expected not 11", cyc, pair);
      end
      chg_prev = (pair !== prev_pair);
      if (chg_prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got={l,r}=%b expected no change", cyc, pair);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || pair !== {e.l, e.r}) begin
            failures++;
            $display("FAIL change cyc=%0d got={l,r}=%b expected cyc=%0d {l,r}=%b%b",
                     cyc, pair, e.cyc, e.l, e.r);
          end
        end
      end
      prev_pair = pair;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic l, input logic r);
    exp_t x;
    x.cyc = c;
    x.l   = l;
    x.r   = r;
    q.push_back(x);
  endtask

  initial begin
    int c;
`ifdef GPIO_LAST_WINS_EN
    last_wins = 1'b1;
`else
    last_wins = 1'b0;
`endif

    // Reset held for three edges with both pins pressed.
    tick(1);
    mon_en = 1'b1;
    tick(2);
    c   = cyc;
    rst = 1'b0;
    // Both lines debounce together: last-wins gives RIGHT, otherwise stays NONE.
    if (last_wins) expect_at(c + Lat, 1'b0, 1'b1);
    tick(12);
    c = cyc;
    gpio_left_raw  = 1'b0;
    gpio_right_raw = 1'b0;
    if (last_wins) expect_at(c + Lat, 1'b0, 1'b0);
    tick(12);

    // Clean press and release on the right line.
    c = cyc;
    gpio_right_raw = 1'b1;
    expect_at(c + Lat, 1'b0, 1'b1);
    tick(12);
    c = cyc;
    gpio_right_raw = 1'b0;
    expect_at(c + Lat, 1'b0, 1'b0);
    tick(12);

    // Bounce 1,0,1,1,0 then a held run of 1s starting at offset 5.
    c = cyc;
    expect_at(c + 5 + Lat, 1'b1, 1'b0);
    gpio_left_raw = 1'b1; tick(1);
    gpio_left_raw = 1'b0; tick(1);
    gpio_left_raw = 1'b1; tick(1);
    gpio_left_raw = 1'b1; tick(1);
    gpio_left_raw = 1'b0; tick(1);
    gpio_left_raw = 1'b1; tick(14);
    c = cyc;
    gpio_left_raw = 1'b0;
    expect_at(c + Lat, 1'b0, 1'b0);
    tick(12);

    // Overlap: left, then right 10 cycles later, release right, then left.
    c = cyc;
    gpio_left_raw = 1'b1;
    expect_at(c + Lat, 1'b1, 1'b0);
    tick(10);
    gpio_right_raw = 1'b1;
    if (last_wins) expect_at(c + 10 + Lat, 1'b0, 1'b1);
    else           expect_at(c + 10 + Lat, 1'b0, 1'b0);
    tick(20);
    gpio_right_raw = 1'b0;
    expect_at(c + 30 + Lat, 1'b1, 1'b0);
    tick(15);
    gpio_left_raw = 1'b0;
    expect_at(c + 45 + Lat, 1'b0, 1'b0);
    tick(14);

    // Reset pulse on the edge after cnt reaches 2; acceptance restarts from re-capture.
    c = cyc;
    gpio_left_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    // Re-capture at edge c+6, accepted DEBOUNCE_CYCLES+2 edges later.
    expect_at(c + 6 + Dc + 2, 1'b1, 1'b0);
    tick(14);
    c = cyc;
    gpio_left_raw = 1'b0;
    expect_at(c + Lat, 1'b0, 1'b0);
    tick(14);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d expected=0 (next cyc=%0d)", q.size(), q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
